// File: rtl/rr_grant_sched.sv
// rr_grant_sched: round-robin grant scheduler for up to N requesters.
// Arbitrates req against a rotating priority pointer, offers the winner as a
// binary index and a one-hot vector under a valid/ready handshake, supports a
// lock that re-offers the same index, and drops a stalled grant after TIMEOUT
// OFFER cycles (TIMEOUT = 0 disables the drop).
//
// Build option: define RR_GRANT_FIXED_PRIO_EN for fixed priority (lowest set
// index always wins, pointer held at 0).
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req          in   [N-1:0] request vector, level-sensitive
//   lock         in   sampled at handshake; 1 re-offers the same requester
//   grant_ready  in   consumer accepts the offered grant
//   grant_valid  out  grant offered (registered)
//   grant_idx    out  [IDX_W-1:0] binary index of the granted requester
//   grant_onehot out  [N-1:0] one-hot grant, zero while grant_valid is 0
//   timeout      out  one-cycle pulse when a stalled grant is dropped
module rr_grant_sched #(
  parameter int unsigned N       = 256,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             lock,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant_onehot,
  output logic             timeout
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, ptr_adv_c, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic [N-1:0]     onehot_d;
  logic             valid_d, timeout_d;

  // First set bit at or above base, wrapping from N-1 to 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r,
                                               input logic [IDX_W-1:0] base);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = base + IDX_W'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Pointer value after a released or dropped grant.
`ifdef RR_GRANT_FIXED_PRIO_EN
  assign ptr_adv_c = '0;
`else
  assign ptr_adv_c = grant_idx + IDX_W'(1);
`endif

  // Saturating stall counter increment.
  assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = grant_idx;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    onehot_d  = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          idx_d   = rr_pick(req, ptr_q);
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end

      OFFER: begin
        valid_d = 1'b1;
        if (grant_ready) begin
          cnt_d = '0;
          if (!lock) begin
            ptr_d = ptr_adv_c;
            if (|req) begin
              // Re-arbitrate against the advanced pointer with no bubble.
              idx_d = rr_pick(req, ptr_adv_c);
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt_inc_c;
          if ((TIMEOUT != 0) && (cnt_inc_c == CNT_W'(TIMEOUT))) begin
            valid_d   = 1'b0;
            timeout_d = 1'b1;
            state_d   = DROP;
          end
        end
      end

      DROP: begin
        ptr_d   = ptr_adv_c;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (valid_d) begin
      onehot_d[idx_d] = 1'b1;
    end
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      grant_valid  <= valid_d;
      grant_idx    <= idx_d;
      grant_onehot <= onehot_d;
      timeout      <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed testbench for rr_grant_sched (N=256, TIMEOUT=4).
module tb_rr_grant_sched;

  localparam int unsigned N       = 256;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned TIMEOUT = 4;

`ifdef RR_GRANT_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic             lock;
  logic             grant_ready;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [N-1:0]     grant_onehot;
  logic             timeout;

  int tests = 0;
  int fails = 0;

  rr_grant_sched #(
    .N       (N),
    .IDX_W   (IDX_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .lock         (lock),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks valid, index (when valid), one-hot and timeout together.
  task automatic chk_grant(input string tag, input logic exp_v, input int exp_idx,
                           input logic exp_to);
    logic [N-1:0] exp_oh;
    exp_oh = '0;
    if (exp_v) exp_oh[exp_idx] = 1'b1;
    chk({tag, "_valid"}, 32'(grant_valid), 32'(exp_v));
    if (exp_v) chk({tag, "_idx"}, 32'(grant_idx), 32'(exp_idx));
    chk({tag, "_to"}, 32'(timeout), 32'(exp_to));
    tests++;
    assert (grant_onehot === exp_oh) else begin
      fails++;
      $error("FAIL %s_onehot: observed %h expected %h", tag, grant_onehot, exp_oh);
    end
  endtask

  initial begin
    req         = '0;
    lock        = 1'b0;
    grant_ready = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    #1;
    chk_grant("rst", 1'b0, 0, 1'b0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      step();
      chk_grant("idle", 1'b0, 0, 1'b0);
      chk("idle_idx", 32'(grant_idx), 32'd0);
    end

`ifndef RR_GRANT_FIXED_PRIO_EN
    // Back-to-back round robin over bits 3, 7, 200.
    req = '0; req[3] = 1'b1; req[7] = 1'b1; req[200] = 1'b1;
    grant_ready = 1'b1;
    step(); chk_grant("b2b0", 1'b1, 3, 1'b0);
    step(); chk_grant("b2b1", 1'b1, 7, 1'b0);
    step(); chk_grant("b2b2", 1'b1, 200, 1'b0);
    step(); chk_grant("b2b3", 1'b1, 3, 1'b0);
    step(); chk_grant("b2b4", 1'b1, 7, 1'b0);
    req = '0;
    step(); chk_grant("b2b_end", 1'b0, 0, 1'b0);

    // Wrap: pointer reaches 255, then wraps through 0.
    req = '0; req[254] = 1'b1;
    step(); chk_grant("wrap_pre", 1'b1, 254, 1'b0);
    req = '0; req[255] = 1'b1; req[0] = 1'b1;
    step(); chk_grant("wrap255", 1'b1, 255, 1'b0);
    step(); chk_grant("wrap0", 1'b1, 0, 1'b0);
    req = '0;
    step(); chk_grant("wrap_end", 1'b0, 0, 1'b0);
`endif

    // Lock holds the grant for two handshakes, then releases.
    req = '0; req[5] = 1'b1; req[9] = 1'b1;
    lock = 1'b1; grant_ready = 1'b1;
    step(); chk_grant("lock0", 1'b1, 5, 1'b0);
    step(); chk_grant("lock1", 1'b1, 5, 1'b0);
    step(); chk_grant("lock2", 1'b1, 5, 1'b0);
    lock = 1'b0;
    step(); chk_grant("lock_rel", 1'b1, FIXED ? 5 : 9, 1'b0);
    req = '0;
    step(); chk_grant("lock_end", 1'b0, 0, 1'b0);

    // Timeout after 4 stalled OFFER cycles, then re-grant.
    req = '0; req[10] = 1'b1; grant_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_grant("to_offer", 1'b1, 10, 1'b0);
    end
    step(); chk_grant("to_drop", 1'b0, 0, 1'b1);
    step(); chk_grant("to_idle", 1'b0, 0, 1'b0);
    step(); chk_grant("to_regrant", 1'b1, 10, 1'b0);
    grant_ready = 1'b1; req = '0;
    step(); chk_grant("to_end", 1'b0, 0, 1'b0);

`ifndef RR_GRANT_FIXED_PRIO_EN
    // Move pointer to 51, then get a wrapped grant on 42 and reset mid-OFFER.
    req = '0; req[50] = 1'b1;
    step(); chk_grant("rs_pre50", 1'b1, 50, 1'b0);
    req = '0; req[42] = 1'b1;
    step(); chk_grant("rs_pre42", 1'b1, 42, 1'b0);
    grant_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_grant("rs_async", 1'b0, 0, 1'b0);
    chk("rs_async_idx", 32'(grant_idx), 32'd0);
    step();
    chk_grant("rs_hold", 1'b0, 0, 1'b0);
    req = '0; req[42] = 1'b1; req[100] = 1'b1;
    grant_ready = 1'b1;
    rst_n = 1'b1;
    step(); chk_grant("rs_first", 1'b1, 42, 1'b0);
    step(); chk_grant("rs_second", 1'b1, 100, 1'b0);
    req = '0;
    step(); chk_grant("rs_end", 1'b0, 0, 1'b0);
`endif

    // Bits 2 and 9: alternate under round robin, 2 always under fixed priority.
    req = '0; req[2] = 1'b1; req[9] = 1'b1; grant_ready = 1'b1;
    step(); chk_grant("fp0", 1'b1, 2, 1'b0);
    step(); chk_grant("fp1", 1'b1, FIXED ? 2 : 9, 1'b0);
    step(); chk_grant("fp2", 1'b1, 2, 1'b0);
    step(); chk_grant("fp3", 1'b1, FIXED ? 2 : 9, 1'b0);
    req = '0;
    step(); chk_grant("fp_end", 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
